// File: rtl/signals.sv
// Control-signal decoder for a small stack machine.
// A one-hot four-phase sequencer (decode -> exec -> rdmem -> fetch) is
// combined with the current instruction to produce the datapath strobes,
// the immediate field mask and the ALU operation select.

package signals_alu_pkg;

    // ALU operation codes shared between this decoder and the ALU.
    localparam logic [5:0] ALU_A    = 6'h00;
    localparam logic [5:0] ALU_ADD  = 6'h01;
    localparam logic [5:0] ALU_ADDZ = 6'h02;
    localparam logic [5:0] ALU_INC2 = 6'h03;
    localparam logic [5:0] ALU_NOT  = 6'h04;
    localparam logic [5:0] ALU_B    = 6'h0F;

endpackage

module signals
    import signals_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] insn,

    output logic        imm,
    output logic        sign,
    output logic        src_a_stk0,
    output logic        src_a_fp,
    output logic        src_a_ip,
    output logic        src_a_cstk,
    output logic        wr_stk1,
    output logic        pop,
    output logic        push,
    output logic        load_stk,
    output logic        load_fp,
    output logic        load_ip,
    output logic        load_insn,
    output logic        cpop,
    output logic        cpush,
    output logic        byt,
    output logic        rd_mem,
    output logic        wr_mem,

    output logic [15:0] imm_mask,
    output logic [5:0]  alu_sel
);

    // One-hot phase encoding; the bit positions match the probe nets below.
    typedef enum logic [3:0] {
        PH_DECODE = 4'b0001,
        PH_EXEC   = 4'b0010,
        PH_RDMEM  = 4'b0100,
        PH_FETCH  = 4'b1000
    } phase_e;

    // Immediate masks for the three immediate-carrying instruction classes.
    localparam logic [15:0] MASK_PUSH = 16'h7FFF;
    localparam logic [15:0] MASK_JUMP = 16'h0FFE;
    localparam logic [15:0] MASK_MEM  = 16'h03FE;

    phase_e phase_q;
    phase_e phase_d;

    // Phase probe nets, kept under these exact names for hierarchical access.
    logic phase_decode;
    logic phase_exec;
    logic phase_rdmem;
    logic phase_fetch;
    logic insn_cpush;

    // Instruction class predicates.
    logic isPushImm;
    logic isJump;
    logic isJumpZero;
    logic isMemGroup;
    logic isMemLoad;
    logic isMemStore;
    logic isMemAddr;
    logic isAluOp;
    logic isGroup7;
    logic isRet;
    logic isLdd;

    // insn[9:7] carry no control meaning here; they only feed the immediate
    // field, which the datapath extracts through imm_mask.
    logic unused_insn_bits;

    assign phase_decode = (phase_q == PH_DECODE);
    assign phase_exec   = (phase_q == PH_EXEC);
    assign phase_rdmem  = (phase_q == PH_RDMEM);
    assign phase_fetch  = (phase_q == PH_FETCH);

    assign isPushImm  = insn[15];
    assign isJump     = (insn[15:12] == 4'b0000);
    assign isJumpZero = (insn[15:12] == 4'b0001);
    assign isMemGroup = (insn[15:13] == 3'b001);
    assign isMemLoad  = isMemGroup && (insn[11:10] == 2'b00);
    assign isMemStore = isMemGroup && (insn[11:10] == 2'b01);
    assign isMemAddr  = isMemGroup && insn[11];
    assign isAluOp    = (insn[15:11] == 5'b01110);
    assign isGroup7   = (insn[15:11] == 5'b01111);
    assign isRet      = isGroup7 && (insn[3:0] == 4'b0000);
    assign isLdd      = isGroup7 && (insn[3:1] == 3'b100);

    // A CALL pushes the return address during decode, before exec moves IP.
    assign insn_cpush = isJump && insn[0];

    assign unused_insn_bits = ^insn[9:7];

    // Advance through the four phases; any illegal encoding recovers to rdmem
    // so the next step is a clean fetch.
    always_comb begin
        phase_d = PH_RDMEM;
        case (phase_q)
            PH_DECODE: phase_d = PH_EXEC;
            PH_EXEC:   phase_d = PH_RDMEM;
            PH_RDMEM:  phase_d = PH_FETCH;
            PH_FETCH:  phase_d = PH_DECODE;
            default:   phase_d = PH_RDMEM;
        endcase
    end

    // Phase register; reset parks in rdmem so the first free edge fetches.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_RDMEM;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Strobe, mask and ALU-select decode from the phase and instruction.
    // While reset is held the outputs are the quiet rdmem pattern regardless
    // of the instruction, so a load sitting in insn cannot touch memory.
    always_comb begin
        imm        = 1'b0;
        sign       = 1'b0;
        src_a_stk0 = 1'b0;
        src_a_fp   = 1'b0;
        src_a_ip   = 1'b0;
        src_a_cstk = 1'b0;
        wr_stk1    = 1'b0;
        pop        = 1'b0;
        push       = 1'b0;
        load_stk   = 1'b0;
        load_fp    = 1'b0;
        load_ip    = 1'b0;
        load_insn  = 1'b0;
        cpop       = 1'b0;
        cpush      = 1'b0;
        byt        = 1'b0;
        rd_mem     = 1'b0;
        wr_mem     = 1'b0;
        imm_mask   = 16'h0000;
        alu_sel    = ALU_A;

        if (rst) begin
            src_a_ip = 1'b1;
        end else begin
            case (phase_q)
                PH_FETCH: begin
                    src_a_ip  = 1'b1;
                    alu_sel   = ALU_INC2;
                    load_ip   = 1'b1;
                    load_insn = 1'b1;
                end

                PH_DECODE: begin
                    src_a_ip = 1'b1;
                    cpush    = insn_cpush;
                end

                PH_EXEC: begin
                    if (isPushImm) begin
                        imm        = 1'b1;
                        imm_mask   = MASK_PUSH;
                        src_a_stk0 = 1'b1;
                        alu_sel    = ALU_B;
                        push       = 1'b1;
                        load_stk   = 1'b1;
                    end else if (isJump || isJumpZero) begin
                        imm      = 1'b1;
                        imm_mask = MASK_JUMP;
                        sign     = 1'b1;
                        src_a_ip = 1'b1;
                        alu_sel  = isJumpZero ? ALU_ADDZ : ALU_ADD;
                        load_ip  = 1'b1;
                        pop      = isJumpZero;
                    end else if (isMemGroup) begin
                        imm        = 1'b1;
                        imm_mask   = MASK_MEM;
                        sign       = 1'b1;
                        src_a_fp   = ~insn[12];
                        src_a_cstk = insn[12];
                        alu_sel    = ALU_ADD;
                        rd_mem     = isMemLoad;
                        wr_mem     = isMemStore;
                        pop        = isMemStore;
                        push       = isMemAddr;
                        load_stk   = isMemAddr;
                    end else if (isAluOp) begin
                        src_a_stk0 = 1'b1;
                        alu_sel    = insn[5:0];
                        pop        = insn[6];
                        load_stk   = 1'b1;
                    end else if (isRet) begin
                        src_a_cstk = 1'b1;
                        load_ip    = 1'b1;
                        cpop       = 1'b1;
                    end else if (isLdd) begin
                        src_a_stk0 = 1'b1;
                        rd_mem     = 1'b1;
                    end else begin
                        src_a_stk0 = 1'b1;
                    end
                end

                PH_RDMEM: begin
                    src_a_ip = 1'b1;
                    if (isMemLoad) begin
                        rd_mem   = 1'b1;
                        push     = 1'b1;
                        load_stk = 1'b1;
                    end else if (isLdd) begin
                        rd_mem   = 1'b1;
                        load_stk = 1'b1;
                        byt      = insn[0];
                    end
                end

                default: begin
                    src_a_ip = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signals.sv
// Directed bench for the signals decoder: walks single instructions through
// the four phases and checks every output against hand-derived patterns.

module tb_signals;
    import signals_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] insn;

    logic imm, sign, src_a_stk0, src_a_fp, src_a_ip, src_a_cstk, wr_stk1;
    logic pop, push, load_stk, load_fp, load_ip, load_insn, cpop, cpush;
    logic byt, rd_mem, wr_mem;
    logic [15:0] imm_mask;
    logic [5:0]  alu_sel;

    int vectors     = 0;
    int miscompares = 0;

    // Strobe bit positions in the packed observation vector.
    localparam bit [17:0] S_IMM    = 18'h20000;
    localparam bit [17:0] S_SIGN   = 18'h10000;
    localparam bit [17:0] S_STK0   = 18'h08000;
    localparam bit [17:0] S_FP     = 18'h04000;
    localparam bit [17:0] S_IP     = 18'h02000;
    localparam bit [17:0] S_CSTK   = 18'h01000;
    localparam bit [17:0] S_WRSTK1 = 18'h00800;
    localparam bit [17:0] S_POP    = 18'h00400;
    localparam bit [17:0] S_PUSH   = 18'h00200;
    localparam bit [17:0] S_LDSTK  = 18'h00100;
    localparam bit [17:0] S_LDFP   = 18'h00080;
    localparam bit [17:0] S_LDIP   = 18'h00040;
    localparam bit [17:0] S_LDINSN = 18'h00020;
    localparam bit [17:0] S_CPOP   = 18'h00010;
    localparam bit [17:0] S_CPUSH  = 18'h00008;
    localparam bit [17:0] S_BYT    = 18'h00004;
    localparam bit [17:0] S_RDMEM  = 18'h00002;
    localparam bit [17:0] S_WRMEM  = 18'h00001;

    localparam bit [3:0] P_DEC   = 4'b0001;
    localparam bit [3:0] P_EXEC  = 4'b0010;
    localparam bit [3:0] P_RDMEM = 4'b0100;
    localparam bit [3:0] P_FETCH = 4'b1000;

    localparam bit [17:0] FETCH_S = S_IP | S_LDIP | S_LDINSN;

    signals dut (
        .clk        (clk),
        .rst        (rst),
        .insn       (insn),
        .imm        (imm),
        .sign       (sign),
        .src_a_stk0 (src_a_stk0),
        .src_a_fp   (src_a_fp),
        .src_a_ip   (src_a_ip),
        .src_a_cstk (src_a_cstk),
        .wr_stk1    (wr_stk1),
        .pop        (pop),
        .push       (push),
        .load_stk   (load_stk),
        .load_fp    (load_fp),
        .load_ip    (load_ip),
        .load_insn  (load_insn),
        .cpop       (cpop),
        .cpush      (cpush),
        .byt        (byt),
        .rd_mem     (rd_mem),
        .wr_mem     (wr_mem),
        .imm_mask   (imm_mask),
        .alu_sel    (alu_sel)
    );

    always #5 clk = ~clk;

    // Drive a new instruction word into the decoder.
    task automatic applyStimulus(input logic [15:0] value);
        insn = value;
    endtask

    // Advance one phase and settle away from the clock edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare phase probes, all strobes, mask and ALU select in one shot.
    task automatic checkOutput(input string tag, input bit [3:0] ePh,
                               input bit [17:0] eS, input bit [15:0] eM,
                               input bit [5:0] eA);
        logic [43:0] obs;
        logic [43:0] exp;
        obs = {dut.phase_fetch, dut.phase_rdmem, dut.phase_exec, dut.phase_decode,
               imm, sign, src_a_stk0, src_a_fp, src_a_ip, src_a_cstk, wr_stk1,
               pop, push, load_stk, load_fp, load_ip, load_insn, cpop, cpush,
               byt, rd_mem, wr_mem, imm_mask, alu_sel};
        exp = {ePh, eS, eM, eA};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed phase=%b strobes=%b mask=%h alu=%h, expected phase=%b strobes=%b mask=%h alu=%h",
                   tag, obs[43:40], obs[39:22], obs[21:6], obs[5:0],
                   exp[43:40], exp[39:22], exp[21:6], exp[5:0]);
        end
    endtask

    initial begin
        // Reset with a load word present: outputs must stay quiet.
        rst = 1'b1;
        applyStimulus(16'h2000);
        tick();
        tick();
        checkOutput("reset_hold", P_RDMEM, S_IP, 16'h0000, ALU_A);

        // Release: first free edge fetches.
        rst = 1'b0;
        applyStimulus(16'h80A5);
        tick();
        checkOutput("release_fetch", P_FETCH, FETCH_S, 16'h0000, ALU_INC2);

        // PUSH immediate 80A5.
        tick();
        checkOutput("push_decode", P_DEC, S_IP, 16'h0000, ALU_A);
        tick();
        checkOutput("push_exec", P_EXEC, S_IMM | S_STK0 | S_PUSH | S_LDSTK, 16'h7FFF, 6'h0F);
        tick();
        checkOutput("push_rdmem", P_RDMEM, S_IP, 16'h0000, ALU_A);
        tick();
        checkOutput("push_fetch", P_FETCH, FETCH_S, 16'h0000, ALU_INC2);

        // CALL 0235.
        applyStimulus(16'h0235);
        tick();
        checkOutput("call_decode", P_DEC, S_IP | S_CPUSH, 16'h0000, ALU_A);
        tick();
        checkOutput("call_exec", P_EXEC, S_IMM | S_SIGN | S_IP | S_LDIP, 16'h0FFE, ALU_ADD);
        tick();
        checkOutput("call_rdmem", P_RDMEM, S_IP, 16'h0000, ALU_A);
        tick();

        // JZ 1234.
        applyStimulus(16'h1234);
        tick();
        checkOutput("jz_decode", P_DEC, S_IP, 16'h0000, ALU_A);
        tick();
        checkOutput("jz_exec", P_EXEC, S_IMM | S_SIGN | S_IP | S_POP | S_LDIP, 16'h0FFE, ALU_ADDZ);
        tick();
        tick();

        // ST via FP 2421.
        applyStimulus(16'h2421);
        tick();
        tick();
        checkOutput("st_exec", P_EXEC, S_IMM | S_SIGN | S_FP | S_POP | S_WRMEM, 16'h03FE, ALU_ADD);
        tick();
        checkOutput("st_rdmem", P_RDMEM, S_IP, 16'h0000, ALU_A);
        tick();

        // Push address via CSTK 3FFE.
        applyStimulus(16'h3FFE);
        tick();
        tick();
        checkOutput("addr_exec", P_EXEC, S_IMM | S_SIGN | S_CSTK | S_PUSH | S_LDSTK, 16'h03FE, ALU_ADD);
        tick();
        tick();

        // LD via FP 2000.
        applyStimulus(16'h2000);
        tick();
        tick();
        checkOutput("ld_exec", P_EXEC, S_IMM | S_SIGN | S_FP | S_RDMEM, 16'h03FE, ALU_ADD);
        tick();
        checkOutput("ld_rdmem", P_RDMEM, S_IP | S_RDMEM | S_PUSH | S_LDSTK, 16'h0000, ALU_A);
        tick();

        // ALU op with pop, 704F.
        applyStimulus(16'h704F);
        tick();
        tick();
        checkOutput("alu_pop_exec", P_EXEC, S_STK0 | S_POP | S_LDSTK, 16'h0000, 6'h0F);
        tick();
        tick();

        // ALU NOT without pop, 7004.
        applyStimulus(16'h7004);
        tick();
        tick();
        checkOutput("alu_not_exec", P_EXEC, S_STK0 | S_LDSTK, 16'h0000, 6'h04);
        tick();
        tick();

        // LDD byte, 7809.
        applyStimulus(16'h7809);
        tick();
        tick();
        checkOutput("ldd_exec", P_EXEC, S_STK0 | S_RDMEM, 16'h0000, ALU_A);
        tick();
        checkOutput("ldd_rdmem", P_RDMEM, S_IP | S_LDSTK | S_RDMEM | S_BYT, 16'h0000, ALU_A);
        tick();

        // RET 7800.
        applyStimulus(16'h7800);
        tick();
        tick();
        checkOutput("ret_exec", P_EXEC, S_CSTK | S_CPOP | S_LDIP, 16'h0000, ALU_A);
        tick();
        tick();

        // Unassigned encoding 4000 is a no-op.
        applyStimulus(16'h4000);
        tick();
        tick();
        checkOutput("noop_exec", P_EXEC, S_STK0, 16'h0000, ALU_A);

        // Reset asserted mid-instruction: outputs quiet, next edge rdmem.
        rst = 1'b1;
        #1;
        checkOutput("midrst_quiet", P_EXEC, S_IP, 16'h0000, ALU_A);
        tick();
        checkOutput("midrst_rdmem", P_RDMEM, S_IP, 16'h0000, ALU_A);
        rst = 1'b0;
        tick();
        checkOutput("midrst_fetch", P_FETCH, FETCH_S, 16'h0000, ALU_INC2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/signals.md
SIGNALS -- requirements
Module: signals

Interface
REQ-001 SHALL have ports: clk in 1, system clock; rst in 1, reset (one clock; reset is synchronous and active-high); insn in 16, current instruction, stable from decode through rdmem.
REQ-002 SHALL output 1-bit strobes: imm, sign, src_a_stk0, src_a_fp, src_a_ip, src_a_cstk, wr_stk1, pop, push, load_stk, load_fp, load_ip, load_insn, cpop, cpush, byt, rd_mem, wr_mem.
- imm: ALU B = insn & imm_mask.
- sign: sign-extend that immediate.
- src_a_*: one-hot ALU A select.
- Remaining strobes: stack, register, call-stack and memory controls.
REQ-003 SHALL output imm_mask[15:0] (immediate field mask) and alu_sel[5:0] (ALU op, codes from the shared ALU header: ALU_A, ALU_B, ALU_ADD, ALU_ADDZ, ALU_NOT, ALU_INC2).
REQ-004 SHALL expose internal nets phase_decode, phase_exec, phase_rdmem, phase_fetch and insn_cpush by these names for hierarchical probing.

Function
REQ-005 SHALL hold a one-hot 4-phase register cycling decode->exec->rdmem->fetch->decode, one phase per clk.
REQ-006 All outputs SHALL be combinational from phase and insn; src_a_* SHALL be one-hot in every phase.
REQ-007 Unlisted outputs SHALL be 0, including imm_mask, sign and wr_stk1.
REQ-008 Fetch: src_a_ip=1, alu_sel=ALU_INC2, load_ip=1, load_insn=1, byt=0; all other strobes 0.
REQ-009 Rdmem, default: src_a_ip=1, alu_sel=ALU_A, all strobes 0.
REQ-010 Decode, default: all strobes 0.
REQ-011 Decode, insn_cpush (insn[15:12]=0000 and insn[0]=1): src_a_ip=1, alu_sel=ALU_A, cpush=1.
REQ-012 Exec, insn[15]=1 (PUSH imm): imm=1, imm_mask=7FFF, sign=0, alu_sel=ALU_B, push=1, load_stk=1.
REQ-013 Exec, insn[15:12]=0000 (JMP; CALL if insn[0]=1): imm=1, imm_mask=0FFE, sign=1, src_a_ip=1, alu_sel=ALU_ADD, load_ip=1.
REQ-014 Exec, insn[15:12]=0001 (JZ): as REQ-013 but alu_sel=ALU_ADDZ and pop=1.
REQ-015 Group 001x, base and offset:
- Base: insn[12]=0 selects FP (src_a_fp=1); insn[12]=1 selects CSTK (src_a_cstk=1).
- Offset: imm=1, imm_mask=03FE, sign=1, alu_sel=ALU_ADD, byt=0.
REQ-016 Group 001x, insn[11:10] operation:
- 00 LD: exec rd_mem=1; rdmem adds rd_mem=1, push=1, load_stk=1.
- 01 ST: exec wr_mem=1, wr_stk1=0, pop=1.
- 1x push address: exec push=1, load_stk=1.
REQ-017 Exec, insn[15:11]=01110 (ALU op):
- src_a_stk0=1, alu_sel=insn[5:0], pop=insn[6], load_stk=1.
- Shared header SHALL define ALU_NOT=04 and ALU_B=0F.
REQ-018 Exec, insn[15:11]=01111 with insn[3:0]=0000 (RET): src_a_cstk=1, alu_sel=ALU_A, load_ip=1, cpop=1.
REQ-019 LDD (insn[15:11]=01111, insn[3:1]=100):
- Exec: src_a_stk0=1, alu_sel=ALU_A, rd_mem=1, no stack strobes.
- Rdmem: load_stk=1, rd_mem=1, byt=insn[0], keeping REQ-009 src/alu.
REQ-020 Other encodings SHALL be no-ops: exec strobes 0, src_a_stk0=1, alu_sel=ALU_A.
REQ-021 load_insn SHALL be 1 only in fetch; cpush SHALL be 1 only in decode.

Reset
REQ-022 While rst=1 the phase SHALL be rdmem and outputs SHALL follow REQ-009 with all strobes 0.
REQ-023 The first clk edge with rst=0 SHALL enter fetch.
REQ-024 rst asserted in any phase SHALL force rdmem at the next edge.

Verification
REQ-025 Reset, release, 1 clk -> phase_fetch=1, load_ip=1, load_insn=1, alu_sel=ALU_INC2.
REQ-026 insn=80A5 -> decode strobes 0; exec imm=1, imm_mask=7FFF, ALU_B, push=1, load_stk=1; then rdmem, fetch.
REQ-027 insn=0235 -> decode cpush=1, src_a_ip=1, ALU_A; exec imm_mask=0FFE, ALU_ADD, load_ip=1.
REQ-028 insn=1234 -> exec ALU_ADDZ, pop=1, load_ip=1.
REQ-029 insn=2421 -> exec src_a_fp=1, imm_mask=03FE, ALU_ADD, pop=1, wr_mem=1, byt=0; insn=3FFE -> exec src_a_cstk=1, push=1, load_stk=1.
REQ-030 704F/7004/7809/7800:
- 704F: exec ALU_B, pop=1, load_stk=1.
- 7004: exec ALU_NOT, src_a_stk0=1, pop=0.
- 7809: exec src_a_stk0=1, ALU_A, load_stk=0; rdmem load_stk=1, byt=1, rd_mem=1.
- 7800: exec src_a_cstk=1, cpop=1, load_ip=1.
